regfile_stack_gen: RTL and testbench
====================================

// Module: regfile_stack_gen
// PURPOSE
//   Parametrised general-purpose register file with a built-in hardware stack
//   pointer. Sits in the decode/writeback stages of the pipelined core: two
//   combinational read ports with write-to-read bypass, one write port, and
//   push/pop control that auto-adjusts the SP register. It also supplies the
//   stack memory address and sticky overflow/underflow flags to the memory stage.
// PARAMETERS
//   DW      8    data width of every register
//   AW      2    register address width; NREG = 2**AW registers
//   SP_RST  255  SP reset value; also the stack-empty value (upper bound)
//   SP_MIN  0    lowest legal SP; a push at SP_MIN overflows
//   BYPASS  1    1: a same-cycle write is forwarded to rd1/rd2; 0: no forwarding
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   ra         in   AW  read address, port 1
//   rb         in   AW  read address, port 2
//   rd1        out  DW  read data, port 1 (combinational)
//   rd2        out  DW  read data, port 2 (combinational)
//   we         in   1   write enable
//   wa         in   AW  write address
//   wd         in   DW  write data
//   sp_push    in   1   pre-decrement SP this cycle
//   sp_pop     in   1   post-increment SP this cycle
//   sp         out  DW  current SP, R[NREG-1], registered, never bypassed
//   stk_addr   out  DW  stack memory address: sp_push ? sp-1 : sp (combinational)
//   clr_flags  in   1   synchronous clear of the sticky flags
//   stk_ovf    out  1   sticky: push attempted at SP==SP_MIN
//   stk_unf    out  1   sticky: pop attempted at SP==SP_RST
// BEHAVIOUR
//   Reset (rst=0, async): R[0..NREG-2]=0, R[NREG-1]=SP_RST, stk_ovf=stk_unf=0.
//     rd1/rd2/stk_addr follow the reset contents combinationally.
//   Write: if we is high at a rising edge, R[wa]<=wd. One-cycle latency to the array.
//   Read: rd1=R[ra], rd2=R[rb]. With BYPASS=1 and we && wa==ra, rd1=wd
//     (same rule for rd2/rb). Bypass forwards only the write port, never push/pop.
//   SP update at a rising edge, in priority order:
//     1. we && wa==NREG-1: explicit write wins; push/pop are ignored this cycle,
//        flags unchanged.
//     2. push && pop together: SP unchanged, no flag change.
//     3. push: if SP==SP_MIN, SP holds and stk_ovf<=1; else SP<=SP-1.
//     4. pop: if SP==SP_RST, SP holds and stk_unf<=1; else SP<=SP+1.
//   Stack convention: full-descending. A push writes memory at SP-1 (stk_addr).
//     A pop reads memory at SP, then SP increments.
//   stk_addr arithmetic is modulo 2**DW and is computed even when a push will
//     overflow. The memory stage must gate its access with stk_ovf-next logic
//     or accept the write.
//   Flags: clr_flags clears both flags at the edge. A flag set condition in the
//     same cycle as clr_flags wins, so the flag stays 1.
//   Reset mid-operation forces the reset state at once, regardless of
//     we/push/pop, and takes no further action on release.
//   Out-of-range SP loaded by an explicit write (e.g. above SP_RST) is
//     accepted. Bounds are checked only by equality at push/pop.
// TESTING
//   1 Reset: rst=0 -> sp=255, rd1(ra=0)=0, flags 0; write R1=0x5A during
//     reset -> R1 still 0 after release.
//   2 Bypass: we=1,wa=2,wd=0x3C,ra=2 -> rd1=0x3C in the same cycle.
//     With BYPASS=0, rd1 is the old value and shows 0x3C only after the edge.
//   3 Push x3 from reset -> stk_addr=254,253,252 in each push cycle; sp ends
//     at 252. Pop x3 -> stk_addr=252,253,254; sp returns to 255.
//   4 Underflow: pop at sp=255 -> sp stays 255, stk_unf=1. With clr_flags
//     and pop together -> stk_unf stays 1. clr_flags alone -> 0.
//   5 Overflow, SP_MIN=250: push until sp=250, push again -> sp=250, stk_ovf=1.
//   6 Conflict: we=1,wa=3,wd=0x80 with push=1 -> sp=0x80, no flag.
//     Then push+pop together -> sp stays 0x80.

Source files
------------

// File: rtl/regfile_stack_gen_if.sv
// Bus between the core pipeline and the register file / stack pointer block.
// The core drives addresses, write data and stack control; the register file returns read data, SP and flags.
interface regfile_stack_gen_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          sp_push;
  logic          sp_pop;
  logic [DW-1:0] sp;
  logic [DW-1:0] stk_addr;
  logic          clr_flags;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output ra, rb, we, wa, wd, sp_push, sp_pop, clr_flags,
    input  rd1, rd2, sp, stk_addr, stk_ovf, stk_unf
  );

  modport slave (
    input  ra, rb, we, wa, wd, sp_push, sp_pop, clr_flags,
    output rd1, rd2, sp, stk_addr, stk_ovf, stk_unf
  );
endinterface

// File: rtl/regfile_stack_gen.sv
// Register file with two bypassed read ports, one write port and a hardware stack pointer in the top register.
// The stack is full-descending: a push uses SP-1 as its address, and a pop uses SP as its address.
module regfile_stack_gen #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int SP_RST = 255,
  parameter int SP_MIN = 0,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               rst,
  regfile_stack_gen_if.slave bus
);
  localparam int            NREG     = 2**AW;
  localparam logic [AW-1:0] SP_IDX   = AW'(NREG-1);
  localparam logic [DW-1:0] SP_RST_V = DW'(SP_RST);
  localparam logic [DW-1:0] SP_MIN_V = DW'(SP_MIN);
  localparam logic [DW-1:0] ONE      = DW'(1);

  logic [DW-1:0] gpr [NREG-1];
  logic [DW-1:0] sp_q;
  logic [DW-1:0] sp_nxt;
  logic          ovf_q;
  logic          ovf_nxt;
  logic          unf_q;
  logic          unf_nxt;
  logic [DW-1:0] rf [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG-1; i++) gpr[i] <= '0;
      sp_q  <= SP_RST_V;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG-1; i++)
        if (bus.we && bus.wa == AW'(i)) gpr[i] <= bus.wd;
      sp_q  <= sp_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // An explicit write to the SP register overrides push/pop. A flag that is being set wins over clr_flags.
  always_comb begin
    sp_nxt  = sp_q;
    ovf_nxt = ovf_q & ~bus.clr_flags;
    unf_nxt = unf_q & ~bus.clr_flags;
    if (bus.we && bus.wa == SP_IDX) begin
      sp_nxt = bus.wd;
    end else if (bus.sp_push && bus.sp_pop) begin
      sp_nxt = sp_q;
    end else if (bus.sp_push) begin
      if (sp_q == SP_MIN_V) ovf_nxt = 1'b1;
      else                  sp_nxt  = sp_q - ONE;
    end else if (bus.sp_pop) begin
      if (sp_q == SP_RST_V) unf_nxt = 1'b1;
      else                  sp_nxt  = sp_q + ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG-1; i++) rf[i] = gpr[i];
    rf[NREG-1] = sp_q;
  end

  // Only the write port is forwarded. Push and pop results appear after the clock edge.
  assign bus.rd1 = (BYPASS != 0 && bus.we && bus.wa == bus.ra) ? bus.wd : rf[bus.ra];
  assign bus.rd2 = (BYPASS != 0 && bus.we && bus.wa == bus.rb) ? bus.wd : rf[bus.rb];

  assign bus.sp       = sp_q;
  assign bus.stk_addr = bus.sp_push ? sp_q - ONE : sp_q;
  assign bus.stk_ovf  = ovf_q;
  assign bus.stk_unf  = unf_q;
endmodule

// File: tb/tb_regfile_stack_gen.sv
// Scoreboard bench. Three instances share one stimulus stream: the default build, a build without bypass, and a build with SP_MIN=250.
// Expected values are queued at each sample point, and a monitor process pops the queue and compares.
module tb_regfile_stack_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] ra = '0, rb = '0, wa = '0;
  logic [7:0] wd = '0;
  logic       we = 1'b0, push = 1'b0, pop = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  regfile_stack_gen_if #(.DW(8), .AW(2)) b0 ();
  regfile_stack_gen_if #(.DW(8), .AW(2)) b1 ();
  regfile_stack_gen_if #(.DW(8), .AW(2)) b2 ();

  assign b0.ra = ra; assign b0.rb = rb; assign b0.we = we; assign b0.wa = wa; assign b0.wd = wd;
  assign b0.sp_push = push; assign b0.sp_pop = pop; assign b0.clr_flags = clr;
  assign b1.ra = ra; assign b1.rb = rb; assign b1.we = we; assign b1.wa = wa; assign b1.wd = wd;
  assign b1.sp_push = push; assign b1.sp_pop = pop; assign b1.clr_flags = clr;
  assign b2.ra = ra; assign b2.rb = rb; assign b2.we = we; assign b2.wa = wa; assign b2.wd = wd;
  assign b2.sp_push = push; assign b2.sp_pop = pop; assign b2.clr_flags = clr;

  regfile_stack_gen #(.DW(8), .AW(2), .SP_RST(255), .SP_MIN(0),   .BYPASS(1)) dut   (.clk(clk), .rst(rst), .bus(b0));
  regfile_stack_gen #(.DW(8), .AW(2), .SP_RST(255), .SP_MIN(0),   .BYPASS(0)) dut_nb  (.clk(clk), .rst(rst), .bus(b1));
  regfile_stack_gen #(.DW(8), .AW(2), .SP_RST(255), .SP_MIN(250), .BYPASS(1)) dut_min (.clk(clk), .rst(rst), .bus(b2));

  typedef enum int {RD1, RD2, SP, ADDR, OVF, UNF, NB_RD1, MIN_SP, MIN_OVF} sig_t;
  typedef struct {string name; sig_t id; logic [7:0] exp;} exp_t;

  exp_t       q[$];
  exp_t       cur;
  event       sample_ev;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] act;

  function automatic logic [7:0] get_act(sig_t id);
    case (id)
      RD1:     return b0.rd1;
      RD2:     return b0.rd2;
      SP:      return b0.sp;
      ADDR:    return b0.stk_addr;
      OVF:     return {7'd0, b0.stk_ovf};
      UNF:     return {7'd0, b0.stk_unf};
      NB_RD1:  return b1.rd1;
      MIN_SP:  return b2.sp;
      MIN_OVF: return {7'd0, b2.stk_ovf};
      default: return 8'hxx;
    endcase
  endfunction

  always begin
    @(sample_ev);
    while (q.size() > 0) begin
      cur = q.pop_front();
      act = get_act(cur.id);
      n_vec++;
      if (act !== cur.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", cur.name, act, cur.exp, $time);
      end
    end
  end

  task automatic chk(input string name, input sig_t id, input logic [7:0] exp);
    exp_t e;
    e.name = name; e.id = id; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic smp();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // The reset state must hold through active clock edges, even while a write is presented.
    we = 1'b1; wa = 2'd1; wd = 8'h5A; ra = 2'd0;
    tick(); tick();
    chk("rst_sp", SP, 8'd255); chk("rst_rd1", RD1, 8'h00);
    chk("rst_ovf", OVF, 8'd0); chk("rst_unf", UNF, 8'd0); chk("rst_addr", ADDR, 8'd255);
    smp();
    rst = 1'b1; idle(); ra = 2'd1;
    chk("rst_r1", RD1, 8'h00); smp();

    // Bypass check
    we = 1'b1; wa = 2'd2; wd = 8'h3C; ra = 2'd2; rb = 2'd2;
    chk("byp_rd1", RD1, 8'h3C); chk("byp_rd2", RD2, 8'h3C); chk("nobyp_old", NB_RD1, 8'h00);
    smp();
    tick(); idle();
    chk("wr_rd1", RD1, 8'h3C); chk("nobyp_new", NB_RD1, 8'h3C); smp();

    // Three pushes followed by three pops
    push = 1'b1;
    chk("push1_addr", ADDR, 8'd254); smp(); tick();
    chk("push2_addr", ADDR, 8'd253); smp(); tick();
    chk("push3_addr", ADDR, 8'd252); smp(); tick();
    push = 1'b0;
    chk("push_sp", SP, 8'd252); chk("push_min_sp", MIN_SP, 8'd252); smp();
    pop = 1'b1;
    chk("pop1_addr", ADDR, 8'd252); smp(); tick();
    chk("pop2_addr", ADDR, 8'd253); smp(); tick();
    chk("pop3_addr", ADDR, 8'd254); smp(); tick();
    pop = 1'b0;
    chk("pop_sp", SP, 8'd255); smp();

    // Underflow, followed by clear tests
    pop = 1'b1; tick(); pop = 1'b0;
    chk("unf_sp", SP, 8'd255); chk("unf_set", UNF, 8'd1); smp();
    pop = 1'b1; clr = 1'b1; tick(); idle();
    chk("unf_clr_pop", UNF, 8'd1); smp();
    clr = 1'b1; tick(); idle();
    chk("unf_clr", UNF, 8'd0); smp();

    // Overflow on the SP_MIN=250 instance: five pushes reach 250, and the sixth push sets the flag
    push = 1'b1;
    repeat (5) tick();
    chk("min_sp250", MIN_SP, 8'd250); chk("min_noovf", MIN_OVF, 8'd0); smp();
    tick(); push = 1'b0;
    chk("min_ovf_sp", MIN_SP, 8'd250); chk("min_ovf", MIN_OVF, 8'd1);
    chk("main_sp249", SP, 8'd249); chk("main_noovf", OVF, 8'd0); smp();

    // An explicit SP write takes priority over push
    we = 1'b1; wa = 2'd3; wd = 8'h80; push = 1'b1; ra = 2'd3;
    chk("sp_wr_byp", RD1, 8'h80); smp();
    tick(); idle();
    chk("conf_sp", SP, 8'h80); chk("conf_ovf", OVF, 8'd0);
    chk("conf_min_sp", MIN_SP, 8'h80); chk("conf_min_ovf", MIN_OVF, 8'd1); smp();
    push = 1'b1; pop = 1'b1;
    chk("pp_addr", ADDR, 8'h7F); smp();
    tick(); idle();
    rb = 2'd3;
    chk("pp_sp", SP, 8'h80); chk("pp_rd2", RD2, 8'h80); chk("pp_unf", UNF, 8'd0); smp();

    // A push at SP_MIN=0 holds SP, and the stack address wraps modulo 256
    we = 1'b1; wa = 2'd3; wd = 8'h00; tick(); idle();
    push = 1'b1;
    chk("wrap_addr", ADDR, 8'hFF); smp();
    tick(); idle();
    chk("ovf0_sp", SP, 8'h00); chk("ovf0_set", OVF, 8'd1); smp();

    // A reset during operation restores the reset state immediately
    push = 1'b1; rst = 1'b0; #1; idle();
    chk("mid_rst_sp", SP, 8'd255); chk("mid_rst_ovf", OVF, 8'd0);
    chk("mid_rst_r2", RD2, 8'd255); smp();
    ra = 2'd2; chk("mid_rst_r2z", RD1, 8'h00); smp();
    rst = 1'b1; tick();
    chk("rel_sp", SP, 8'd255); smp();

    for (int i = 0; i < 20 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
